// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: takes bitstream words from the upstream configuration
// slave over a valid/ready handshake and shifts them LSB-first into the
// fabric configuration chain. Once the chain is full it drives the fabric
// latch strobe for a fixed number of cycles.
module cfg_chain_loader #(
  parameter int WORD_W     = 32,
  parameter int CHAIN_LEN  = 4096,
  parameter int SET_CYCLES = 2,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              start,
  input  logic              abort,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              cfg_shift,
  output logic              cfg_data,
  output logic              cfg_set,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int IDX_W  = $clog2(WORD_W + 1);
  localparam int SCNT_W = $clog2(SET_CYCLES + 1);

  // Compare against "last value" constants so each exit is decided on the
  // same edge that performs the final increment.
  localparam logic [CNT_W-1:0]  CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0]  WORD_LAST  = IDX_W'(WORD_W - 1);
  localparam logic [SCNT_W-1:0] SET_LAST   = SCNT_W'(SET_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SET,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [SCNT_W-1:0]   set_q,   set_d;

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
    end
  end

  // Next-state logic and state-decoded outputs; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    set_d     = set_q;
    wr_ready  = 1'b0;
    cfg_shift = 1'b0;
    cfg_data  = 1'b0;
    cfg_set   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (wr_valid) begin
          shift_d = wr_data;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cfg_shift = 1'b1;
        cfg_data  = shift_q[0];
        busy      = 1'b1;
        shift_d   = shift_q >> 1;
        idx_d     = idx_q + IDX_W'(1);
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CHAIN_LAST) begin
          state_d = ST_SET;
          set_d   = '0;
        end else if (idx_q == WORD_LAST) begin
          state_d = ST_LOAD;
        end
      end
      ST_SET: begin
        cfg_set = 1'b1;
        busy    = 1'b1;
        if (set_q == SET_LAST) begin
          state_d = ST_DONE;
        end else begin
          set_d = set_q + SCNT_W'(1);
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      shift_d = '0;
      idx_d   = '0;
      cnt_d   = '0;
      set_d   = '0;
    end
  end

  assign bit_count = cnt_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Testbench for cfg_chain_loader. Two instances (chain lengths 32 and 40)
// share one stimulus stream; a queue-based behavioural model predicts every
// output of both instances each cycle.
module tb_cfg_chain_loader;

  localparam int WORD_W     = 32;
  localparam int SET_CYCLES = 2;
  localparam int LEN_A      = 32;
  localparam int LEN_B      = 40;
  localparam int CW_A       = $clog2(LEN_A + 1);
  localparam int CW_B       = $clog2(LEN_B + 1);

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_SHIFT = 2;
  localparam int M_SET   = 3;
  localparam int M_DONE  = 4;

  logic              clock    = 1'b0;
  logic              resetb   = 1'b0;
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic              wr_valid = 1'b0;
  logic [WORD_W-1:0] wr_data  = '0;

  logic            wr_ready_a, cfg_shift_a, cfg_data_a, cfg_set_a, busy_a, done_a;
  logic [CW_A-1:0] bit_count_a;
  logic            wr_ready_b, cfg_shift_b, cfg_data_b, cfg_set_b, busy_b, done_b;
  logic [CW_B-1:0] bit_count_b;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: pending chain bits per instance held in a queue
  int m_mode[2];
  int m_count[2];
  int m_set_left[2];
  bit q0[$];
  bit q1[$];

  // observed serial stream and strobe cycles per instance
  logic [63:0] cap_a, cap_b;
  int cap_na, cap_nb, set_na, set_nb;

  always #5 clock = ~clock;

  cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_A), .SET_CYCLES(SET_CYCLES)) dut_a (
    .clock(clock), .resetb(resetb), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_a),
    .cfg_shift(cfg_shift_a), .cfg_data(cfg_data_a), .cfg_set(cfg_set_a),
    .busy(busy_a), .done(done_a), .bit_count(bit_count_a)
  );

  cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_B), .SET_CYCLES(SET_CYCLES)) dut_b (
    .clock(clock), .resetb(resetb), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_b),
    .cfg_shift(cfg_shift_b), .cfg_data(cfg_data_b), .cfg_set(cfg_set_b),
    .busy(busy_b), .done(done_b), .bit_count(bit_count_b)
  );

  function automatic int len_of(int i);
    return (i == 0) ? LEN_A : LEN_B;
  endfunction

  function automatic int q_size(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic q_push(int i, bit b);
    if (i == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic q_pop(int i);
    bit dummy;
    if (i == 0) dummy = q0.pop_front();
    else dummy = q1.pop_front();
  endtask

  task automatic q_clear(int i);
    if (i == 0) q0.delete();
    else q1.delete();
  endtask

  function automatic logic exp_data(int i);
    if (m_mode[i] != M_SHIFT || q_size(i) == 0) return 1'b0;
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i]     = M_IDLE;
      m_count[i]    = 0;
      m_set_left[i] = 0;
      q_clear(i);
    end
  endtask

  // One rising edge of the behavioural model, using the inputs now driven.
  task automatic model_step();
    int n;
    if (!resetb) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (abort) begin
        m_mode[i]  = M_IDLE;
        m_count[i] = 0;
        q_clear(i);
      end else begin
        case (m_mode[i])
          M_IDLE, M_DONE: begin
            if (start) begin
              m_mode[i]  = M_LOAD;
              m_count[i] = 0;
            end
          end
          M_LOAD: begin
            if (wr_valid) begin
              n = WORD_W;
              if (len_of(i) - m_count[i] < n) n = len_of(i) - m_count[i];
              for (int b = 0; b < n; b++) q_push(i, wr_data[b]);
              m_mode[i] = M_SHIFT;
            end
          end
          M_SHIFT: begin
            q_pop(i);
            m_count[i]++;
            if (q_size(i) == 0) begin
              if (m_count[i] == len_of(i)) begin
                m_mode[i]     = M_SET;
                m_set_left[i] = SET_CYCLES;
              end else begin
                m_mode[i] = M_LOAD;
              end
            end
          end
          M_SET: begin
            m_set_left[i]--;
            if (m_set_left[i] == 0) m_mode[i] = M_DONE;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string what);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL timeout %s: event not seen, expected within cycle bound", what);
  endtask

  // Compare both instances against the model at the current sample point.
  task automatic checkOutput();
    check("a.wr_ready",  32'(wr_ready_a),  32'(m_mode[0] == M_LOAD));
    check("a.cfg_shift", 32'(cfg_shift_a), 32'(m_mode[0] == M_SHIFT));
    check("a.cfg_data",  32'(cfg_data_a),  32'(exp_data(0)));
    check("a.cfg_set",   32'(cfg_set_a),   32'(m_mode[0] == M_SET));
    check("a.busy",      32'(busy_a),      32'(m_mode[0] inside {M_LOAD, M_SHIFT, M_SET}));
    check("a.done",      32'(done_a),      32'(m_mode[0] == M_DONE));
    check("a.bit_count", 32'(bit_count_a), 32'(m_count[0]));
    check("b.wr_ready",  32'(wr_ready_b),  32'(m_mode[1] == M_LOAD));
    check("b.cfg_shift", 32'(cfg_shift_b), 32'(m_mode[1] == M_SHIFT));
    check("b.cfg_data",  32'(cfg_data_b),  32'(exp_data(1)));
    check("b.cfg_set",   32'(cfg_set_b),   32'(m_mode[1] == M_SET));
    check("b.busy",      32'(busy_b),      32'(m_mode[1] inside {M_LOAD, M_SHIFT, M_SET}));
    check("b.done",      32'(done_b),      32'(m_mode[1] == M_DONE));
    check("b.bit_count", 32'(bit_count_b), 32'(m_count[1]));
  endtask

  task automatic clear_capture();
    cap_a = '0; cap_b = '0;
    cap_na = 0; cap_nb = 0; set_na = 0; set_nb = 0;
  endtask

  // One clock: drive at the falling edge, step the model at the rising
  // edge, check and record at the following falling edge.
  task automatic applyStimulus(logic s, logic a, logic v, logic [WORD_W-1:0] d);
    start    = s;
    abort    = a;
    wr_valid = v;
    wr_data  = d;
    @(posedge clock);
    model_step();
    @(negedge clock);
    checkOutput();
    if (cfg_shift_a) begin
      if (cap_na < 64) cap_a[cap_na] = cfg_data_a;
      cap_na++;
    end
    if (cfg_shift_b) begin
      if (cap_nb < 64) cap_b[cap_nb] = cfg_data_b;
      cap_nb++;
    end
    if (cfg_set_a) set_na++;
    if (cfg_set_b) set_nb++;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    start = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clock);
    checkOutput();
    check("reset.a.outputs", 32'({wr_ready_a, cfg_shift_a, cfg_data_a, cfg_set_a, busy_a, done_a, bit_count_a}), 32'd0);
    check("reset.b.outputs", 32'({wr_ready_b, cfg_shift_b, cfg_data_b, cfg_set_b, busy_b, done_b, bit_count_b}), 32'd0);
    resetb = 1'b1;
  endtask

  typedef struct {
    logic              s, a, v;
    logic [WORD_W-1:0] d;
    logic              e_rdy, e_sh, e_dat, e_busy, e_done;
    logic [5:0]        e_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 500 us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    logic [WORD_W-1:0] dw;
    bit saw_done;

    // inputs (start, abort, valid, data) and expected outputs after the edge
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};

    clear_capture();
    do_reset();

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d.wr_ready", i),  32'(wr_ready_b),  32'(vecs[i].e_rdy));
      check($sformatf("vec%0d.cfg_shift", i), 32'(cfg_shift_b), 32'(vecs[i].e_sh));
      check($sformatf("vec%0d.cfg_data", i),  32'(cfg_data_b),  32'(vecs[i].e_dat));
      check($sformatf("vec%0d.busy", i),      32'(busy_b),      32'(vecs[i].e_busy));
      check($sformatf("vec%0d.done", i),      32'(done_b),      32'(vecs[i].e_done));
      check($sformatf("vec%0d.bit_count", i), 32'(bit_count_b), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d.a.bit_count", i), 32'(bit_count_a), 32'(vecs[i].e_cnt));
    end

    $display("[TB] single word into 32-bit chain");
    do_reset();
    clear_capture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F);
    guard = 0;
    while (!done_a && guard < 60) begin idle(); guard++; end
    if (!done_a) timeout_fail("single word done");
    check("one.a.shift_cycles", 32'(cap_na), 32'd32);
    check("one.a.stream",       cap_a[31:0], 32'hA5A5_0F0F);
    check("one.a.first_bits",   32'(cap_a[7:0]), 32'h0F);
    check("one.a.set_cycles",   32'(set_na), 32'd2);
    check("one.a.bit_count",    32'(bit_count_a), 32'd32);

    $display("[TB] two words into 40-bit chain with backpressure");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    clear_capture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    guard = 0;
    while (!wr_ready_b && guard < 60) begin idle(); guard++; end
    if (!wr_ready_b) timeout_fail("second load");
    for (int c = 0; c < 10; c++) begin
      idle();
      check("bp.wr_ready",  32'(wr_ready_b),  32'd1);
      check("bp.cfg_shift", 32'(cfg_shift_b), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_00F0);
    check("bp.resume_shift",    32'(cfg_shift_b), 32'd1);
    check("bp.ready_dropped",   32'(wr_ready_b),  32'd0);
    guard = 0;
    while (!done_b && guard < 60) begin idle(); guard++; end
    if (!done_b) timeout_fail("two word done");
    check("two.b.shift_cycles", 32'(cap_nb), 32'd40);
    check("two.b.first_word",   cap_b[31:0], 32'hFFFF_FFFF);
    check("two.b.last_bits",    32'(cap_b[39:32]), 32'hF0);
    check("two.b.bit_count",    32'(bit_count_b), 32'd40);
    check("two.b.set_cycles",   32'(set_nb), 32'd2);
    check("two.a.shift_cycles", 32'(cap_na), 32'd32);

    $display("[TB] abort mid-word then reload");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    clear_capture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
    guard = 0;
    while (bit_count_b != 6'd17 && guard < 60) begin idle(); guard++; end
    if (bit_count_b != 6'd17) timeout_fail("bit 17");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    check("abort.a.outputs", 32'({wr_ready_a, cfg_shift_a, cfg_data_a, cfg_set_a, busy_a, done_a, bit_count_a}), 32'd0);
    check("abort.b.outputs", 32'({wr_ready_b, cfg_shift_b, cfg_data_b, cfg_set_b, busy_b, done_b, bit_count_b}), 32'd0);
    repeat (4) idle();
    check("abort.no_set", 32'(set_na + set_nb), 32'd0);
    clear_capture();
    dw = $urandom;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, dw);
    check("reload.bit_count", 32'(bit_count_a), 32'd0);
    check("reload.first_bit", 32'(cfg_data_a), 32'(dw[0]));

    $display("[TB] start pulses during shift and set");
    guard = 0;
    while (!done_a && guard < 100) begin
      applyStimulus(busy_a && ((guard % 5) == 0 || cfg_set_a), 1'b0, 1'b0, '0);
      guard++;
    end
    if (!done_a) timeout_fail("start-ignored done");
    check("ign.a.stream",     cap_a[31:0], dw);
    check("ign.a.shift_cycles", 32'(cap_na), 32'd32);
    check("ign.a.set_cycles", 32'(set_na), 32'd2);
    check("ign.a.bit_count",  32'(bit_count_a), 32'd32);

    $display("[TB] asynchronous reset during set");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
    guard = 0;
    while (!cfg_set_a && guard < 60) begin idle(); guard++; end
    if (!cfg_set_a) timeout_fail("set strobe");
    #2;
    resetb = 1'b0;
    model_reset();
    #1;
    check("rst.cfg_set", 32'(cfg_set_a), 32'd0);
    check("rst.busy",    32'(busy_a),    32'd0);
    check("rst.done",    32'(done_a),    32'd0);
    @(negedge clock);
    repeat (3) idle();
    resetb = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (done_a || cfg_set_a) saw_done = 1'b1;
    end
    check("rst.no_done_after", 32'(saw_done), 32'd0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(15) == 0, $urandom_range(199) == 0,
                    1'($urandom_range(1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
